// File: rtl/fifo_ecc_pkg.sv
// fifo_ecc_pkg
//   Shared SECDED definitions for the ECC-protected FIFO datapath. The
//   write-side encoder, the read-side decoder and the bench all use these
//   functions, so the codeword layout is defined in exactly one place.
//   Layout: cw[0] = overall even parity over cw[71:1]; cw[i] (i=1..71) is
//   Hamming position i; check bits at 1,2,4,...,64; data bits d0..d63 fill
//   the remaining positions in ascending order.
package fifo_ecc_pkg;

    localparam int DATA_WIDTH   = 64;
    localparam int PARITY_WIDTH = 7;
    localparam int CW_WIDTH     = DATA_WIDTH + PARITY_WIDTH + 1;

    typedef struct packed {
        logic sec;
        logic ded;
    } ecc_status_t;

    // Hamming position of data bit dk: the k-th non-power-of-two position.
    function automatic int data_pos(input int k);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        for (int p = 3; p < CW_WIDTH; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == k) pos = p;
                n++;
            end
        end
        return pos;
    endfunction

    // XOR of the indices of all set bits in positions 1..71.
    function automatic logic [PARITY_WIDTH-1:0] ecc_syndrome(input logic [CW_WIDTH-1:0] cw);
        logic [PARITY_WIDTH-1:0] s;
        s = '0;
        for (int i = 1; i < CW_WIDTH; i++) begin
            if (cw[7'(i)]) s = s ^ PARITY_WIDTH'(i);
        end
        return s;
    endfunction

    function automatic logic [CW_WIDTH-1:0] ecc_encode(input logic [DATA_WIDTH-1:0] data);
        logic [CW_WIDTH-1:0]     cw;
        logic [PARITY_WIDTH-1:0] s;
        cw = '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            cw[7'(data_pos(k))] = data[6'(k)];
        end
        // Setting check bit 2^j adds 2^j to the syndrome, so copying the
        // data-only syndrome into the check positions zeroes it.
        s = ecc_syndrome(cw);
        for (int j = 0; j < PARITY_WIDTH; j++) begin
            cw[7'(1 << j)] = s[3'(j)];
        end
        cw[0] = ^cw[CW_WIDTH-1:1];
        return cw;
    endfunction

endpackage

// File: rtl/fifo_ecc_syndrome.sv
// fifo_ecc_syndrome
//   Combinational Hamming syndrome and overall parity of one codeword.
//   Ports:
//     i_cw        codeword (CW_WIDTH)
//     o_syndrome  XOR of indices of set bits 1..71 (PARITY_WIDTH)
//     o_parity    XOR of all codeword bits; 1 means odd number of flips
module fifo_ecc_syndrome
    import fifo_ecc_pkg::*;
(
    input  logic [CW_WIDTH-1:0]     i_cw,
    output logic [PARITY_WIDTH-1:0] o_syndrome,
    output logic                    o_parity
);

    assign o_syndrome = ecc_syndrome(i_cw);
    assign o_parity   = ^i_cw;

endmodule

// File: rtl/fifo_ecc_decoder.sv
// fifo_ecc_decoder
//   Read-side SECDED decoder. Two-stage stall-all pipeline: stage 1 captures
//   the raw codeword with its syndrome and overall parity, stage 2 corrects
//   and registers the outputs. Saturating SEC/DED event counters count words
//   on the output handshake.
//   Ports:
//     i_clk, i_rst                 clock, asynchronous active-high reset
//     i_in_valid / o_in_ready      input handshake
//     i_in_cw                      72-bit codeword
//     o_out_valid / i_out_ready    output handshake
//     o_out_data                   corrected data (raw data bits on DED)
//     o_out_sec / o_out_ded        per-word error status
//     o_out_syndrome               Hamming syndrome of the word
//     i_clear_counts               synchronous counter clear
//     o_sec_count / o_ded_count    saturating event counters
module fifo_ecc_decoder
    import fifo_ecc_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [CW_WIDTH-1:0]     i_in_cw,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [DATA_WIDTH-1:0]   o_out_data,
    output logic                    o_out_sec,
    output logic                    o_out_ded,
    output logic [PARITY_WIDTH-1:0] o_out_syndrome,
    input  logic                    i_clear_counts,
    output logic [COUNT_WIDTH-1:0]  o_sec_count,
    output logic [COUNT_WIDTH-1:0]  o_ded_count
);

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A clear coinciding with an event leaves that event counted.
    function automatic logic [COUNT_WIDTH-1:0] cnt_next(input logic [COUNT_WIDTH-1:0] cur,
                                                        input logic inc,
                                                        input logic clr);
        if (clr)      return inc ? COUNT_WIDTH'(1) : '0;
        else if (inc) return sat_inc(cur);
        else          return cur;
    endfunction

    logic                    w_adv;
    logic                    w_hs;
    logic [PARITY_WIDTH-1:0] w_syn;
    logic                    w_par;

    logic                    r_vld_p1;
    logic [CW_WIDTH-1:0]     r_cw_p1;
    logic [PARITY_WIDTH-1:0] r_syn_p1;
    logic                    r_par_p1;

    logic                    w_syn_nz;
    logic                    w_in_range;
    logic                    w_flip;
    ecc_status_t             w_status;
    logic [CW_WIDTH-1:0]     w_cw_fix;
    logic [DATA_WIDTH-1:0]   w_data;

    logic                    r_vld_p2;
    logic [DATA_WIDTH-1:0]   r_data_p2;
    ecc_status_t             r_status_p2;
    logic [PARITY_WIDTH-1:0] r_syn_p2;

    logic [COUNT_WIDTH-1:0]  r_sec_cnt;
    logic [COUNT_WIDTH-1:0]  r_ded_cnt;

    // Whole pipeline moves together; nothing moves while the output is stalled.
    assign w_adv      = !r_vld_p2 || i_out_ready;
    assign o_in_ready = w_adv;
    assign w_hs       = r_vld_p2 && i_out_ready;

    // ---- stage 1: raw codeword, syndrome, overall parity ----
    fifo_ecc_syndrome u_syndrome (
        .i_cw       (i_in_cw),
        .o_syndrome (w_syn),
        .o_parity   (w_par)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1 <= i_in_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_adv && i_in_valid) begin
            r_cw_p1  <= i_in_cw;
            r_syn_p1 <= w_syn;
            r_par_p1 <= w_par;
        end
    end

    // ---- stage 2: classify, correct, register outputs ----
    always_comb begin
        w_syn_nz        = |r_syn_p1;
        w_in_range      = r_syn_p1 <= 7'(CW_WIDTH - 1);
        w_flip          = w_syn_nz && r_par_p1 && w_in_range;
        // s==0 with odd parity means only cw[0] flipped: SEC, data untouched.
        w_status.sec    = r_par_p1 && w_in_range;
        w_status.ded    = (w_syn_nz && !r_par_p1) || (r_par_p1 && !w_in_range);
        w_cw_fix        = r_cw_p1;
        if (w_flip) begin
            w_cw_fix = r_cw_p1 ^ (CW_WIDTH'(1) << r_syn_p1);
        end
        w_data = '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            w_data[6'(k)] = w_cw_fix[7'(data_pos(k))];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld_p2    <= 1'b0;
            r_data_p2   <= '0;
            r_status_p2 <= '0;
            r_syn_p2    <= '0;
        end else if (w_adv) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2   <= w_data;
                r_status_p2 <= w_status;
                r_syn_p2    <= r_syn_p1;
            end
        end
    end

    // ---- event counters on output handshake ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else begin
            r_sec_cnt <= cnt_next(r_sec_cnt, w_hs && r_status_p2.sec, i_clear_counts);
            r_ded_cnt <= cnt_next(r_ded_cnt, w_hs && r_status_p2.ded, i_clear_counts);
        end
    end

    assign o_out_valid    = r_vld_p2;
    assign o_out_data     = r_data_p2;
    assign o_out_sec      = r_status_p2.sec;
    assign o_out_ded      = r_status_p2.ded;
    assign o_out_syndrome = r_syn_p2;
    assign o_sec_count    = r_sec_cnt;
    assign o_ded_count    = r_ded_cnt;

endmodule

// File: tb/tb_fifo_ecc_decoder.sv
// tb_fifo_ecc_decoder
//   Directed bench for fifo_ecc_decoder. A second instance with 4-bit
//   counters shares the stimulus so counter saturation is reachable quickly.
module tb_fifo_ecc_decoder;
    import fifo_ecc_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic [CW_WIDTH-1:0]     in_cw;
    logic                    out_ready;
    logic                    clear_counts;

    logic                    in_ready;
    logic                    out_valid;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_sec;
    logic                    out_ded;
    logic [PARITY_WIDTH-1:0] out_syn;
    logic [15:0]             sec_cnt;
    logic [15:0]             ded_cnt;

    logic                    b_in_ready;
    logic                    b_out_valid;
    logic [DATA_WIDTH-1:0]   b_out_data;
    logic                    b_out_sec;
    logic                    b_out_ded;
    logic [PARITY_WIDTH-1:0] b_out_syn;
    logic [3:0]              b_sec_cnt;
    logic [3:0]              b_ded_cnt;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    fifo_ecc_decoder u_dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_cw        (in_cw),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_data     (out_data),
        .o_out_sec      (out_sec),
        .o_out_ded      (out_ded),
        .o_out_syndrome (out_syn),
        .i_clear_counts (clear_counts),
        .o_sec_count    (sec_cnt),
        .o_ded_count    (ded_cnt)
    );

    fifo_ecc_decoder #(.COUNT_WIDTH(4)) u_dut4 (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_in_valid     (in_valid),
        .o_in_ready     (b_in_ready),
        .i_in_cw        (in_cw),
        .o_out_valid    (b_out_valid),
        .i_out_ready    (out_ready),
        .o_out_data     (b_out_data),
        .o_out_sec      (b_out_sec),
        .o_out_ded      (b_out_ded),
        .o_out_syndrome (b_out_syn),
        .i_clear_counts (clear_counts),
        .o_sec_count    (b_sec_cnt),
        .o_ded_count    (b_ded_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One word into an empty pipeline with out_ready=1; returns in the
    // cycle where that word is on the outputs.
    task automatic push_wait(input logic [CW_WIDTH-1:0] cw);
        in_valid = 1'b1;
        in_cw    = cw;
        step();
        in_valid = 1'b0;
        step();
    endtask

    function automatic logic [63:0] word_of(input int i);
        return {16{4'(i)}} ^ 64'hF0E1_D2C3_B4A5_9687;
    endfunction

    logic [CW_WIDTH-1:0] one72;
    logic [63:0]         prev_data;
    logic                prev_stall;
    int                  tx;
    int                  rx;
    int                  cyc;

    initial begin
        one72        = {{(CW_WIDTH-1){1'b0}}, 1'b1};
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_cw        = '0;
        out_ready    = 1'b1;
        clear_counts = 1'b0;
        step();
        step();

        // reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_data",  out_data,       64'd0);
        chk("rst_syn",       64'(out_syn),   64'd0);
        chk("rst_status",    64'({out_sec, out_ded}), 64'd0);
        chk("rst_counts",    64'({sec_cnt, ded_cnt}), 64'd0);
        rst = 1'b0;
        step();

        // clean words, two-cycle latency
        in_valid = 1'b1;
        in_cw    = ecc_encode(64'h0);
        step();
        chk("lat_not_yet", 64'(out_valid), 64'd0);
        in_cw = ecc_encode(64'hDEAD_BEEF_0123_4567);
        step();
        in_valid = 1'b0;
        chk("clean0_valid", 64'(out_valid), 64'd1);
        chk("clean0_data",  out_data, 64'h0);
        chk("clean0_stat",  64'({out_sec, out_ded}), 64'd0);
        chk("clean0_syn",   64'(out_syn), 64'd0);
        step();
        chk("clean1_valid", 64'(out_valid), 64'd1);
        chk("clean1_data",  out_data, 64'hDEAD_BEEF_0123_4567);
        chk("clean1_stat",  64'({out_sec, out_ded}), 64'd0);
        chk("clean1_syn",   64'(out_syn), 64'd0);
        step();
        chk("clean_drain", 64'(out_valid), 64'd0);

        // single error at position 3 (d0)
        push_wait(ecc_encode(64'h0) ^ (one72 << 3));
        chk("sec3_data", out_data, 64'h0);
        chk("sec3_sec",  64'(out_sec), 64'd1);
        chk("sec3_ded",  64'(out_ded), 64'd0);
        chk("sec3_syn",  64'(out_syn), 64'd3);
        step();
        chk("sec3_cnt",  64'(sec_cnt), 64'd1);
        chk("sec3_cnt4", 64'(b_sec_cnt), 64'd1);

        // overall parity bit only
        push_wait(ecc_encode(64'h0) ^ one72);
        chk("secp_data", out_data, 64'h0);
        chk("secp_sec",  64'(out_sec), 64'd1);
        chk("secp_syn",  64'(out_syn), 64'd0);
        step();
        chk("secp_cnt",  64'(sec_cnt), 64'd2);

        // single error at position 40 on a nonzero word
        push_wait(ecc_encode(64'hDEAD_BEEF_0123_4567) ^ (one72 << 40));
        chk("sec40_data", out_data, 64'hDEAD_BEEF_0123_4567);
        chk("sec40_syn",  64'(out_syn), 64'd40);
        step();
        chk("sec40_cnt",  64'(sec_cnt), 64'd3);

        // double error at 5 and 9: raw d1 and d4 pass through
        push_wait(ecc_encode(64'h0) ^ (one72 << 5) ^ (one72 << 9));
        chk("ded_ded",  64'(out_ded), 64'd1);
        chk("ded_sec",  64'(out_sec), 64'd0);
        chk("ded_syn",  64'(out_syn), 64'd12);
        chk("ded_data", out_data, 64'h12);
        step();
        chk("ded_cnt",  64'(ded_cnt), 64'd1);
        chk("ded_seccnt", 64'(sec_cnt), 64'd3);

        // three flips at 64,8,1: syndrome 73 out of range, odd parity
        push_wait(ecc_encode(64'h0) ^ (one72 << 64) ^ (one72 << 8) ^ (one72 << 1));
        chk("oor_ded",  64'(out_ded), 64'd1);
        chk("oor_sec",  64'(out_sec), 64'd0);
        chk("oor_syn",  64'(out_syn), 64'd73);
        chk("oor_data", out_data, 64'h0);
        step();
        chk("oor_cnt",  64'(ded_cnt), 64'd2);

        // backpressure: 10 words, out_ready low for 5 cycles mid-stream
        tx         = 0;
        rx         = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (rx < 10 && cyc < 60) begin
            out_ready = !(cyc >= 3 && cyc < 8);
            in_valid  = (tx < 10);
            in_cw     = ecc_encode(word_of(tx));
            #1;
            if (prev_stall) begin
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_data",  out_data, prev_data);
            end
            if (out_valid && !out_ready) begin
                chk("bp_in_ready", 64'(in_ready), 64'd0);
            end
            if (out_valid && out_ready) begin
                chk("bp_data", out_data, word_of(rx));
                rx++;
            end
            if (in_valid && in_ready) tx++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_rx_count", 64'(rx), 64'd10);
        step();
        step();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // 20 single-error words streamed back to back
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_cw    = ecc_encode(64'(i) * 64'h0101) ^ (one72 << (3 + i));
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("sat_cnt16", 64'(sec_cnt), 64'd23);
        chk("sat_cnt4",  64'(b_sec_cnt), 64'd15);
        chk("sat_ded4",  64'(b_ded_cnt), 64'd2);

        // clear together with a SEC handshake
        push_wait(ecc_encode(64'h0) ^ (one72 << 3));
        clear_counts = 1'b1;
        step();
        clear_counts = 1'b0;
        chk("clr_sec16", 64'(sec_cnt), 64'd1);
        chk("clr_sec4",  64'(b_sec_cnt), 64'd1);
        chk("clr_ded16", 64'(ded_cnt), 64'd0);
        chk("clr_ded4",  64'(b_ded_cnt), 64'd0);

        // reset with two SEC words in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_cw     = ecc_encode(64'h0) ^ (one72 << 3);
        step();
        in_cw = ecc_encode(64'h1) ^ (one72 << 5);
        step();
        in_valid = 1'b0;
        chk("fl_valid",    64'(out_valid), 64'd1);
        chk("fl_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("fl_still",    64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mr_valid",    64'(out_valid), 64'd0);
        chk("mr_in_ready", 64'(in_ready), 64'd1);
        chk("mr_counts",   64'({sec_cnt, ded_cnt}), 64'd0);
        chk("mr_counts4",  64'({b_sec_cnt, b_ded_cnt}), 64'd0);
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("pr_empty", 64'(out_valid), 64'd0);
        push_wait(ecc_encode(64'hCAFE_F00D_1234_5678));
        chk("pr_valid", 64'(out_valid), 64'd1);
        chk("pr_data",  out_data, 64'hCAFE_F00D_1234_5678);
        chk("pr_stat",  64'({out_sec, out_ded}), 64'd0);
        step();
        chk("pr_counts", 64'({sec_cnt, ded_cnt}), 64'd0);
        chk("pr_drain",  64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
